branch_predictor_btb: RTL and testbench
=======================================

Name: branch_predictor_btb

Overview:
- Fetch-side branch target buffer with 2-bit saturating direction counters for the 16-bit pipelined core.
- Predicts next PC in IF from the current PC.
- Consumes branch resolution from ID (bcond, computed target, prediction carried down the pipe), raises mispredict with the corrected PC, and trains its table.
- Also keeps resolved-branch and mispredict statistics counters.

Parameters:
- WORD_SIZE, 16, datapath and PC width.
- INDEX_BITS, 4, table index width; 2**INDEX_BITS entries, indexed by pc[INDEX_BITS-1:0].
- TAG_BITS, WORD_SIZE-INDEX_BITS, tag width; tag = pc[WORD_SIZE-1:INDEX_BITS].

Ports:
- clk  input  1  clock. All state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- if_pc  input  WORD_SIZE  PC of the instruction being fetched.
- pred_taken  output  1  IF prediction: taken.
- pred_next_pc  output  WORD_SIZE  predicted next fetch PC.
- id_valid  input  1  ID holds a real instruction (not a bubble, not stalled).
- id_is_branch  input  1  ID instruction is BNE/BEQ/BGZ/BLZ.
- id_is_jump  input  1  ID instruction is an unconditional direct jump (JMP/JAL).
- id_pc  input  WORD_SIZE  PC of the ID instruction.
- id_bcond  input  1  branch outcome from the resolve unit.
- id_target  input  WORD_SIZE  computed branch/jump target.
- id_pred_taken  input  1  pred_taken carried from IF with this instruction.
- id_pred_next_pc  input  WORD_SIZE  pred_next_pc carried from IF.
- mispredict  output  1  flush IF/ID and redirect fetch.
- correct_pc  output  WORD_SIZE  redirect PC, valid when mispredict=1.
- branch_count  output  WORD_SIZE  resolved conditional branches, saturating.
- miss_count  output  WORD_SIZE  mispredicts, saturating.

Behaviour:
Storage:
- Per entry: valid, tag[TAG_BITS], target[WORD_SIZE], ctr[2].

Reset (reset_n=0 at a clock edge):
- All valid=0, ctr=2'b01, tag/target=0.
- branch_count=0, miss_count=0.
- Combinational outputs then follow from the cleared table: pred_taken=0, pred_next_pc=if_pc+1.
- Reset takes priority over any same-cycle update, including one mid-training.

Lookup (combinational, 0-cycle):
- idx=if_pc[INDEX_BITS-1:0].
- hit = valid[idx] && tag[idx]==if_pc tag.
- pred_taken = hit && ctr[idx][1].
- pred_next_pc = pred_taken ? target[idx] : if_pc+1. PC is word-addressed; increment by 1, wrapping 16'hFFFF -> 16'h0000.

Resolution (combinational):
- act = id_is_jump ? 1 : id_bcond.
- actual_pc = act ? id_target : id_pc+1.
- mispredict = id_valid && (id_is_branch || id_is_jump) && (id_pred_next_pc != actual_pc).
- correct_pc = actual_pc; drive 0 when mispredict=0.
- id_is_branch and id_is_jump both high is illegal; id_is_jump wins.

Training (at clock edge, when id_valid=1; entry e = id_pc index):
- Branch hit (valid and tag match):
  - ctr += 1 if id_bcond, saturating at 3.
  - ctr -= 1 if !id_bcond, saturating at 0.
  - target = id_target when id_bcond.
- Branch miss, id_bcond=1: allocate (overwriting any conflicting entry): valid=1, tag, target=id_target, ctr=2'b10.
- Branch miss, id_bcond=0: no write.
- Jump: write valid=1, tag, target=id_target, ctr=2'b11, hit or miss.
- id_valid=0 or neither flag set: no table write, no counter change.

Statistics:
- branch_count += 1 per edge with id_valid && id_is_branch.
- miss_count += 1 per edge with mispredict=1 (jumps included).
- Both saturate at 16'hFFFF.

Same-cycle read/write to the same index:
- Lookup sees pre-edge contents; the write is visible from the next cycle (no bypass).

Stall handling:
- The pipeline deasserts id_valid while ID is stalled, so an instruction trains exactly once.

Test Plan:
- Reset, then if_pc=16'h0010 -> pred_taken=0, pred_next_pc=16'h0011; branch_count=miss_count=0.
- Cold BEQ: id_pc=16'h0010, bcond=1, target=16'h0020, pred_next_pc=16'h0011 -> mispredict=1, correct_pc=16'h0020, miss_count=1. Next cycle if_pc=16'h0010 -> pred_taken=1, pred_next_pc=16'h0020.
- Same branch trained not-taken twice (ctr 10->01->00) -> after first update pred_taken=0; third resolution not-taken with pred_next_pc=16'h0011 -> mispredict=0; ctr stays 00.
- Aliasing: entry for 16'h0010 valid; if_pc=16'h0110 (same index, different tag) -> pred_taken=0. Taken branch at 16'h0110 replaces the entry, and 16'h0010 then misses.
- JMP at id_pc=16'h0005, target=16'h0040, predicted 16'h0006 -> mispredict=1, correct_pc=16'h0040; entry ctr=11. Not-taken-style branch update never applies to jumps.
- Apply reset_n=0 in the same cycle as a taken-branch allocation -> table cleared, counters 0, lookup of that PC misses; force branch_count to 16'hFFFF and resolve -> stays 16'hFFFF.

Source files
------------

// File: rtl/branch_predictor_btb.sv
// Fetch-side branch target buffer with 2-bit saturating direction counters.
// IF looks up the current PC combinationally; ID resolves branches/jumps,
// flags mispredicts with the corrected PC and trains the table on the edge.
// Saturating counters track resolved conditional branches and mispredicts.
module branch_predictor_btb #(
    parameter int WORD_SIZE  = 16,
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = WORD_SIZE - INDEX_BITS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] if_pc,
    output logic                 pred_taken,
    output logic [WORD_SIZE-1:0] pred_next_pc,
    input  logic                 id_valid,
    input  logic                 id_is_branch,
    input  logic                 id_is_jump,
    input  logic [WORD_SIZE-1:0] id_pc,
    input  logic                 id_bcond,
    input  logic [WORD_SIZE-1:0] id_target,
    input  logic                 id_pred_taken,
    input  logic [WORD_SIZE-1:0] id_pred_next_pc,
    output logic                 mispredict,
    output logic [WORD_SIZE-1:0] correct_pc,
    output logic [WORD_SIZE-1:0] branch_count,
    output logic [WORD_SIZE-1:0] miss_count
);

    localparam int                   ENTRIES   = 1 << INDEX_BITS;
    localparam logic [WORD_SIZE-1:0] PC_ONE    = WORD_SIZE'(1);
    localparam logic [WORD_SIZE-1:0] COUNT_MAX = '1;
    localparam logic [1:0]           CTR_INIT  = 2'b01;  // weakly not-taken
    localparam logic [1:0]           CTR_ALLOC = 2'b10;  // weakly taken
    localparam logic [1:0]           CTR_JUMP  = 2'b11;  // strongly taken

    // Flattened read views of the per-entry registers held in g_entry.
    logic                 entry_valid  [ENTRIES];
    logic [TAG_BITS-1:0]  entry_tag    [ENTRIES];
    logic [WORD_SIZE-1:0] entry_target [ENTRIES];
    logic [1:0]           entry_ctr    [ENTRIES];
    logic [ENTRIES-1:0]   entry_we;

    // ------------------------------------------------------------------
    // IF lookup: reads pre-edge table contents, no bypass from training.
    // ------------------------------------------------------------------
    logic [INDEX_BITS-1:0] if_idx;
    logic [TAG_BITS-1:0]   if_tag;
    logic                  if_hit;

    assign if_idx       = if_pc[INDEX_BITS-1:0];
    assign if_tag       = if_pc[WORD_SIZE-1:INDEX_BITS];
    assign if_hit       = entry_valid[if_idx] && (entry_tag[if_idx] == if_tag);
    assign pred_taken   = if_hit && entry_ctr[if_idx][1];
    assign pred_next_pc = pred_taken ? entry_target[if_idx] : if_pc + PC_ONE;

    // ------------------------------------------------------------------
    // ID resolution. A jump is always taken and overrides the branch flag.
    // The carried next PC alone decides a mispredict; the carried taken bit
    // is implied by it and deliberately not consulted.
    // ------------------------------------------------------------------
    logic                 id_control;
    logic                 id_actual_taken;
    logic [WORD_SIZE-1:0] id_actual_pc;
    logic                 unused_pred_taken;

    assign unused_pred_taken = id_pred_taken;
    assign id_control        = id_is_branch || id_is_jump;
    assign id_actual_taken   = id_is_jump ? 1'b1 : id_bcond;
    assign id_actual_pc      = id_actual_taken ? id_target : id_pc + PC_ONE;
    assign mispredict        = id_valid && id_control && (id_pred_next_pc != id_actual_pc);
    assign correct_pc        = mispredict ? id_actual_pc : '0;

    // ------------------------------------------------------------------
    // Training: decide whether and what to write into the ID entry.
    // ------------------------------------------------------------------
    logic [INDEX_BITS-1:0] id_idx;
    logic [TAG_BITS-1:0]   id_tag;
    logic                  id_hit;
    logic [1:0]            id_entry_ctr;
    logic [WORD_SIZE-1:0]  id_entry_target;
    logic                  wr_en;
    logic [WORD_SIZE-1:0]  wr_target;
    logic [1:0]            wr_ctr;

    assign id_idx          = id_pc[INDEX_BITS-1:0];
    assign id_tag          = id_pc[WORD_SIZE-1:INDEX_BITS];
    assign id_hit          = entry_valid[id_idx] && (entry_tag[id_idx] == id_tag);
    assign id_entry_ctr    = entry_ctr[id_idx];
    assign id_entry_target = entry_target[id_idx];

    // Write-data selection: jumps always (re)install strongly taken, branch
    // hits nudge the counter, taken branch misses allocate weakly taken.
    always_comb begin
        wr_en     = 1'b0;
        wr_target = id_target;
        wr_ctr    = CTR_ALLOC;
        if (id_valid) begin
            if (id_is_jump) begin
                wr_en  = 1'b1;
                wr_ctr = CTR_JUMP;
            end else if (id_is_branch) begin
                if (id_hit) begin
                    wr_en = 1'b1;
                    if (id_bcond) begin
                        wr_target = id_target;
                        wr_ctr    = (id_entry_ctr == 2'b11) ? 2'b11 : id_entry_ctr + 2'd1;
                    end else begin
                        wr_target = id_entry_target;
                        wr_ctr    = (id_entry_ctr == 2'b00) ? 2'b00 : id_entry_ctr - 2'd1;
                    end
                end else if (id_bcond) begin
                    wr_en  = 1'b1;
                    wr_ctr = CTR_ALLOC;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Table storage, one register set per entry.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic                 valid_reg;
            logic [TAG_BITS-1:0]  tag_reg;
            logic [WORD_SIZE-1:0] target_reg;
            logic [1:0]           ctr_reg;

            assign entry_we[gi] = wr_en && (id_idx == INDEX_BITS'(gi));

            // Entry state: cleared by reset (which wins over training), else
            // rewritten as a whole when this entry is the training target.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    valid_reg  <= 1'b0;
                    tag_reg    <= '0;
                    target_reg <= '0;
                    ctr_reg    <= CTR_INIT;
                end else if (entry_we[gi]) begin
                    valid_reg  <= 1'b1;
                    tag_reg    <= id_tag;
                    target_reg <= wr_target;
                    ctr_reg    <= wr_ctr;
                end
            end

            assign entry_valid[gi]  = valid_reg;
            assign entry_tag[gi]    = tag_reg;
            assign entry_target[gi] = target_reg;
            assign entry_ctr[gi]    = ctr_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Statistics counters, saturating at all-ones.
    // ------------------------------------------------------------------
    logic [WORD_SIZE-1:0] branch_count_reg;
    logic [WORD_SIZE-1:0] branch_count_next;
    logic [WORD_SIZE-1:0] miss_count_reg;
    logic [WORD_SIZE-1:0] miss_count_next;

    // Next-count logic: hold unless an event occurs and headroom remains.
    always_comb begin
        branch_count_next = branch_count_reg;
        miss_count_next   = miss_count_reg;
        if (id_valid && id_is_branch && (branch_count_reg != COUNT_MAX)) begin
            branch_count_next = branch_count_reg + PC_ONE;
        end
        if (mispredict && (miss_count_reg != COUNT_MAX)) begin
            miss_count_next = miss_count_reg + PC_ONE;
        end
    end

    // Counter registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            branch_count_reg <= '0;
            miss_count_reg   <= '0;
        end else begin
            branch_count_reg <= branch_count_next;
            miss_count_reg   <= miss_count_next;
        end
    end

    assign branch_count = branch_count_reg;
    assign miss_count   = miss_count_reg;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb. Each scenario task drives
// one transaction per cycle, pushes the expected outputs onto a scoreboard
// queue, then pops and compares once the DUT outputs settle (negedge).
module tb_branch_predictor_btb;

    typedef struct packed {
        logic [15:0] ifpc;
        logic        v;
        logic        br;
        logic        jmp;
        logic [15:0] pc;
        logic        bcond;
        logic [15:0] tgt;
        logic [15:0] pnpc;
        logic        ept;
        logic [15:0] epnpc;
        logic        emp;
        logic [15:0] ecpc;
    } stim_t;

    typedef struct packed {
        logic        pt;
        logic [15:0] npc;
        logic        mp;
        logic [15:0] cpc;
        logic [15:0] bc;
        logic [15:0] mc;
    } out_t;

    typedef struct {
        string name;
        out_t  o;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] if_pc;
    logic        pred_taken;
    logic [15:0] pred_next_pc;
    logic        id_valid;
    logic        id_is_branch;
    logic        id_is_jump;
    logic [15:0] id_pc;
    logic        id_bcond;
    logic [15:0] id_target;
    logic        id_pred_taken;
    logic [15:0] id_pred_next_pc;
    logic        mispredict;
    logic [15:0] correct_pc;
    logic [15:0] branch_count;
    logic [15:0] miss_count;

    int          checks   = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    logic [15:0] exp_bc   = 16'h0000;
    logic [15:0] exp_mc   = 16'h0000;

    always #5 clk = ~clk;

    branch_predictor_btb dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .if_pc           (if_pc),
        .pred_taken      (pred_taken),
        .pred_next_pc    (pred_next_pc),
        .id_valid        (id_valid),
        .id_is_branch    (id_is_branch),
        .id_is_jump      (id_is_jump),
        .id_pc           (id_pc),
        .id_bcond        (id_bcond),
        .id_target       (id_target),
        .id_pred_taken   (id_pred_taken),
        .id_pred_next_pc (id_pred_next_pc),
        .mispredict      (mispredict),
        .correct_pc      (correct_pc),
        .branch_count    (branch_count),
        .miss_count      (miss_count)
    );

    function automatic stim_t mk(input logic [15:0] ifpc, input logic v, br, jmp,
                                 input logic [15:0] pc, input logic bcond,
                                 input logic [15:0] tgt, pnpc, input logic ept,
                                 input logic [15:0] epnpc, input logic emp,
                                 input logic [15:0] ecpc);
        stim_t s;
        s = '{ifpc, v, br, jmp, pc, bcond, tgt, pnpc, ept, epnpc, emp, ecpc};
        return s;
    endfunction

    function automatic stim_t idle(input logic [15:0] ifpc, input logic ept,
                                   input logic [15:0] epnpc);
        return mk(ifpc, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, ept, epnpc, 1'b0, 16'h0);
    endfunction

    function automatic out_t observe();
        out_t o;
        o = '{pred_taken, pred_next_pc, mispredict, correct_pc, branch_count, miss_count};
        return o;
    endfunction

    // Drive one transaction just after the edge, push its expected outputs
    // (counters as seen before the next edge), then advance the counter model.
    task automatic apply(input string name, input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        if_pc           = s.ifpc;
        id_valid        = s.v;
        id_is_branch    = s.br;
        id_is_jump      = s.jmp;
        id_pc           = s.pc;
        id_bcond        = s.bcond;
        id_target       = s.tgt;
        id_pred_next_pc = s.pnpc;
        id_pred_taken   = (s.pnpc != s.pc + 16'h0001);
        e.name = name;
        e.o    = '{s.ept, s.epnpc, s.emp, s.ecpc, exp_bc, exp_mc};
        exp_q.push_back(e);
        if (s.v && s.br && exp_bc != 16'hFFFF) exp_bc = exp_bc + 16'h0001;
        if (s.emp && exp_mc != 16'hFFFF) exp_mc = exp_mc + 16'h0001;
    endtask

    task automatic test_reset();
        stim_t rows [2];
        exp_t  e;
        out_t  obs;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        exp_bc = 16'h0000;
        exp_mc = 16'h0000;
        rows[0] = idle(16'h0010, 1'b0, 16'h0011);
        rows[1] = idle(16'hFFFF, 1'b0, 16'h0000);
        for (int i = 0; i < $size(rows); i++) begin
            apply($sformatf("reset[%0d]", i), rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            obs = observe();
            checks++;
            if (obs !== e.o) begin
                failures++;
                $display("FAIL %s: got pt=%b npc=%h mp=%b cpc=%h bc=%h mc=%h want pt=%b npc=%h mp=%b cpc=%h bc=%h mc=%h",
                         e.name, obs.pt, obs.npc, obs.mp, obs.cpc, obs.bc, obs.mc,
                         e.o.pt, e.o.npc, e.o.mp, e.o.cpc, e.o.bc, e.o.mc);
            end else begin
                $display("txn %s: pt=%b npc=%h mp=%b cpc=%h bc=%h mc=%h",
                         e.name, obs.pt, obs.npc, obs.mp, obs.cpc, obs.bc, obs.mc);
            end
        end
    endtask

    task automatic test_cold_branch();
        stim_t rows [2];
        exp_t  e;
        out_t  obs;
        // Same-cycle lookup of the PC being allocated still misses.
        rows[0] = mk(16'h0010, 1, 1, 0, 16'h0010, 1, 16'h0020, 16'h0011, 0, 16'h0011, 1, 16'h0020);
        rows[1] = idle(16'h0010, 1'b1, 16'h0020);
        for (int i = 0; i < $size(rows); i++) begin
            apply($sformatf("cold[%0d]", i), rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            obs = observe();
            checks++;
            if (obs !== e.o) begin
                failures++;
                $display("FAIL %s: got pt=%b npc=%h mp=%b cpc=%h bc=%h mc=%h want pt=%b npc=%h mp=%b cpc=%h bc=%h mc=%h",
                         e.name, obs.pt, obs.npc, obs.mp, obs.cpc, obs.bc, obs.mc,
                         e.o.pt, e.o.npc, e.o.mp, e.o.cpc, e.o.bc, e.o.mc);
            end else begin
                $display("txn %s: pt=%b npc=%h mp=%b cpc=%h bc=%h mc=%h",
                         e.name, obs.pt, obs.npc, obs.mp, obs.cpc, obs.bc, obs.mc);
            end
        end
    endtask

    task automatic test_counter_training();
        stim_t rows [11];
        exp_t  e;
        out_t  obs;
        // ctr 10 -> 01 -> 00 -> 00 (floor) -> 01 -> 10 -> 11 -> 11 (ceiling) -> 10
        rows[0]  = mk(16'h0010, 1, 1, 0, 16'h0010, 0, 16'h0020, 16'h0020, 1, 16'h0020, 1, 16'h0011);
        rows[1]  = mk(16'h0010, 1, 1, 0, 16'h0010, 0, 16'h0020, 16'h0011, 0, 16'h0011, 0, 16'h0000);
        rows[2]  = mk(16'h0010, 1, 1, 0, 16'h0010, 0, 16'h0020, 16'h0011, 0, 16'h0011, 0, 16'h0000);
        rows[3]  = mk(16'h0010, 1, 1, 0, 16'h0010, 1, 16'h0020, 16'h0011, 0, 16'h0011, 1, 16'h0020);
        rows[4]  = idle(16'h0010, 1'b0, 16'h0011);
        rows[5]  = mk(16'h0010, 1, 1, 0, 16'h0010, 1, 16'h0020, 16'h0011, 0, 16'h0011, 1, 16'h0020);
        rows[6]  = idle(16'h0010, 1'b1, 16'h0020);
        rows[7]  = mk(16'h0010, 1, 1, 0, 16'h0010, 1, 16'h0020, 16'h0020, 1, 16'h0020, 0, 16'h0000);
        rows[8]  = mk(16'h0010, 1, 1, 0, 16'h0010, 1, 16'h0030, 16'h0020, 1, 16'h0020, 1, 16'h0030);
        rows[9]  = mk(16'h0010, 1, 1, 0, 16'h0010, 0, 16'h0099, 16'h0030, 1, 16'h0030, 1, 16'h0011);
        rows[10] = idle(16'h0010, 1'b1, 16'h0030);
        for (int i = 0; i < $size(rows); i++) begin
            apply($sformatf("train[%0d]", i), rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            obs = observe();
            checks++;
            if (obs !== e.o) begin
                failures++;
                $display("FAIL %s: got pt=%b npc=%h mp=%b cpc=%h bc=%h mc=%h want pt=%b npc=%h mp=%b cpc=%h bc=%h mc=%h",
                         e.name, obs.pt, obs.npc, obs.mp, obs.cpc, obs.bc, obs.mc,
                         e.o.pt, e.o.npc, e.o.mp, e.o.cpc, e.o.bc, e.o.mc);
            end else begin
                $display("txn %s: pt=%b npc=%h mp=%b cpc=%h bc=%h mc=%h",
                         e.name, obs.pt, obs.npc, obs.mp, obs.cpc, obs.bc, obs.mc);
            end
        end
    endtask

    task automatic test_aliasing();
        stim_t rows [7];
        exp_t  e;
        out_t  obs;
        rows[0] = idle(16'h0110, 1'b0, 16'h0111);
        rows[1] = mk(16'h0010, 1, 1, 0, 16'h0110, 1, 16'h0200, 16'h0111, 1, 16'h0030, 1, 16'h0200);
        rows[2] = idle(16'h0010, 1'b0, 16'h0011);
        rows[3] = idle(16'h0110, 1'b1, 16'h0200);
        // Not-taken miss at the same index must not allocate.
        rows[4] = mk(16'h0110, 1, 1, 0, 16'h0020, 0, 16'h0300, 16'h0021, 1, 16'h0200, 0, 16'h0000);
        rows[5] = idle(16'h0110, 1'b1, 16'h0200);
        rows[6] = idle(16'h0020, 1'b0, 16'h0021);
        for (int i = 0; i < $size(rows); i++) begin
            apply($sformatf("alias[%0d]", i), rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            obs = observe();
            checks++;
            if (obs !== e.o) begin
                failures++;
                $display("FAIL %s: got pt=%b npc=%h mp=%b cpc=%h bc=%h mc=%h want pt=%b npc=%h mp=%b cpc=%h bc=%h mc=%h",
                         e.name, obs.pt, obs.npc, obs.mp, obs.cpc, obs.bc, obs.mc,
                         e.o.pt, e.o.npc, e.o.mp, e.o.cpc, e.o.bc, e.o.mc);
            end else begin
                $display("txn %s: pt=%b npc=%h mp=%b cpc=%h bc=%h mc=%h",
                         e.name, obs.pt, obs.npc, obs.mp, obs.cpc, obs.bc, obs.mc);
            end
        end
    endtask

    task automatic test_jump();
        stim_t rows [7];
        exp_t  e;
        out_t  obs;
        // bcond=0 on every jump: jumps are taken regardless and never decrement.
        rows[0] = mk(16'h0005, 1, 0, 1, 16'h0005, 0, 16'h0040, 16'h0006, 0, 16'h0006, 1, 16'h0040);
        rows[1] = idle(16'h0005, 1'b1, 16'h0040);
        rows[2] = mk(16'h0005, 1, 0, 1, 16'h0005, 0, 16'h0040, 16'h0040, 1, 16'h0040, 0, 16'h0000);
        rows[3] = mk(16'h0005, 1, 0, 1, 16'h0005, 0, 16'h0040, 16'h0040, 1, 16'h0040, 0, 16'h0000);
        rows[4] = idle(16'h0005, 1'b1, 16'h0040);
        rows[5] = mk(16'h0005, 1, 0, 1, 16'h0005, 0, 16'h0044, 16'h0040, 1, 16'h0040, 1, 16'h0044);
        rows[6] = idle(16'h0005, 1'b1, 16'h0044);
        for (int i = 0; i < $size(rows); i++) begin
            apply($sformatf("jump[%0d]", i), rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            obs = observe();
            checks++;
            if (obs !== e.o) begin
                failures++;
                $display("FAIL %s: got pt=%b npc=%h mp=%b cpc=%h bc=%h mc=%h want pt=%b npc=%h mp=%b cpc=%h bc=%h mc=%h",
                         e.name, obs.pt, obs.npc, obs.mp, obs.cpc, obs.bc, obs.mc,
                         e.o.pt, e.o.npc, e.o.mp, e.o.cpc, e.o.bc, e.o.mc);
            end else begin
                $display("txn %s: pt=%b npc=%h mp=%b cpc=%h bc=%h mc=%h",
                         e.name, obs.pt, obs.npc, obs.mp, obs.cpc, obs.bc, obs.mc);
            end
        end
    endtask

    task automatic test_invalid_id();
        stim_t rows [3];
        exp_t  e;
        out_t  obs;
        rows[0] = mk(16'h0005, 0, 1, 0, 16'h0005, 0, 16'h0070, 16'h1234, 1, 16'h0044, 0, 16'h0000);
        rows[1] = mk(16'h0005, 1, 0, 0, 16'h0005, 1, 16'h0070, 16'h1234, 1, 16'h0044, 0, 16'h0000);
        rows[2] = idle(16'h0005, 1'b1, 16'h0044);
        for (int i = 0; i < $size(rows); i++) begin
            apply($sformatf("noop[%0d]", i), rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            obs = observe();
            checks++;
            if (obs !== e.o) begin
                failures++;
                $display("FAIL %s: got pt=%b npc=%h mp=%b cpc=%h bc=%h mc=%h want pt=%b npc=%h mp=%b cpc=%h bc=%h mc=%h",
                         e.name, obs.pt, obs.npc, obs.mp, obs.cpc, obs.bc, obs.mc,
                         e.o.pt, e.o.npc, e.o.mp, e.o.cpc, e.o.bc, e.o.mc);
            end else begin
                $display("txn %s: pt=%b npc=%h mp=%b cpc=%h bc=%h mc=%h",
                         e.name, obs.pt, obs.npc, obs.mp, obs.cpc, obs.bc, obs.mc);
            end
        end
    endtask

    task automatic test_reset_mid_training();
        stim_t rows [4];
        exp_t  e;
        out_t  obs;
        rows[0] = mk(16'h0033, 1, 1, 0, 16'h0033, 1, 16'h0077, 16'h0034, 0, 16'h0034, 1, 16'h0077);
        rows[1] = idle(16'h0033, 1'b0, 16'h0034);
        rows[2] = idle(16'h0005, 1'b0, 16'h0006);
        rows[3] = idle(16'h0010, 1'b0, 16'h0011);
        for (int i = 0; i < $size(rows); i++) begin
            apply($sformatf("rstmid[%0d]", i), rows[i]);
            // Reset is held low across exactly the edge that would allocate row 0.
            reset_n = (i == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            e = exp_q.pop_front();
            obs = observe();
            checks++;
            if (obs !== e.o) begin
                failures++;
                $display("FAIL %s: got pt=%b npc=%h mp=%b cpc=%h bc=%h mc=%h want pt=%b npc=%h mp=%b cpc=%h bc=%h mc=%h",
                         e.name, obs.pt, obs.npc, obs.mp, obs.cpc, obs.bc, obs.mc,
                         e.o.pt, e.o.npc, e.o.mp, e.o.cpc, e.o.bc, e.o.mc);
            end else begin
                $display("txn %s: pt=%b npc=%h mp=%b cpc=%h bc=%h mc=%h",
                         e.name, obs.pt, obs.npc, obs.mp, obs.cpc, obs.bc, obs.mc);
            end
            if (i == 0) begin
                exp_bc = 16'h0000;
                exp_mc = 16'h0000;
            end
        end
    endtask

    task automatic test_stat_saturation();
        stim_t rows [3];
        exp_t  e;
        out_t  obs;
        // Bulk phase: 65535 mispredicted taken branches drive both counters to the top.
        @(posedge clk);
        #1;
        if_pc = 16'h0041; id_valid = 1'b1; id_is_branch = 1'b1; id_is_jump = 1'b0;
        id_pc = 16'h0040; id_bcond = 1'b1; id_target = 16'h0050;
        id_pred_next_pc = 16'h0000; id_pred_taken = 1'b1;
        for (int n = 0; n < 65535; n++) begin
            @(posedge clk);
            if (exp_bc != 16'hFFFF) exp_bc = exp_bc + 16'h0001;
            if (exp_mc != 16'hFFFF) exp_mc = exp_mc + 16'h0001;
        end
        #1;
        id_valid = 1'b0; id_is_branch = 1'b0;
        $display("txn sat_bulk: 65535 mispredicted branches driven");
        rows[0] = idle(16'h0040, 1'b1, 16'h0050);
        rows[1] = mk(16'h0040, 1, 1, 0, 16'h0040, 1, 16'h0050, 16'h0000, 1, 16'h0050, 1, 16'h0050);
        rows[2] = idle(16'h0041, 1'b0, 16'h0042);
        for (int i = 0; i < $size(rows); i++) begin
            apply($sformatf("sat[%0d]", i), rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            obs = observe();
            checks++;
            if (obs !== e.o) begin
                failures++;
                $display("FAIL %s: got pt=%b npc=%h mp=%b cpc=%h bc=%h mc=%h want pt=%b npc=%h mp=%b cpc=%h bc=%h mc=%h",
                         e.name, obs.pt, obs.npc, obs.mp, obs.cpc, obs.bc, obs.mc,
                         e.o.pt, e.o.npc, e.o.mp, e.o.cpc, e.o.bc, e.o.mc);
            end else begin
                $display("txn %s: pt=%b npc=%h mp=%b cpc=%h bc=%h mc=%h",
                         e.name, obs.pt, obs.npc, obs.mp, obs.cpc, obs.bc, obs.mc);
            end
        end
    endtask

    initial begin
        reset_n         = 1'b0;
        if_pc           = 16'h0000;
        id_valid        = 1'b0;
        id_is_branch    = 1'b0;
        id_is_jump      = 1'b0;
        id_pc           = 16'h0000;
        id_bcond        = 1'b0;
        id_target       = 16'h0000;
        id_pred_taken   = 1'b0;
        id_pred_next_pc = 16'h0000;

        test_reset();
        test_cold_branch();
        test_counter_training();
        test_aliasing();
        test_jump();
        test_invalid_id();
        test_reset_mid_training();
        test_stat_saturation();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
